// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, control rows
// and the per-row register control word.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_STEP   = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    ROW_RESET     = 3'd0,
    ROW_MEM_STALL = 3'd1,
    ROW_REDIRECT  = 3'd2,
    ROW_HALTED    = 3'd3,
    ROW_LOAD_USE  = 3'd4,
    ROW_DEFAULT   = 3'd5
  } row_e;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_flush;
  } ctrl_t;

  function automatic ctrl_t row_ctrl(input row_e row);
    ctrl_t c;
    case (row)
      ROW_RESET:     c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      ROW_MEM_STALL: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ROW_REDIRECT:  c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ROW_HALTED:    c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ROW_LOAD_USE:  c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ROW_DEFAULT:   c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      default:       c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over en.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // count register: clear, saturating increment, or hold
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: load-use / redirect / mem-wait hazard controls,
// debug halt/single-step FSM and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_br_taken,
  input  logic              ex_jump,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              dbg_halt,
  input  logic              dbg_step,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_flush,
  output logic              exmem_write,
  output logic              memwb_flush,
  output logic              halted,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_r;
  state_e     state_nxt_s;
  row_e       row_s;
  ctrl_t      ctrl_s;
  logic       load_use_s;
  logic       redirect_s;
  logic       mem_stall_s;
  logic       stall_en_s;
  logic       flush_en_s;
  logic       wait_clr_s;
  logic [7:0] wait_cnt_s;
  logic       mem_timeout_r;

  assign load_use_s  = ex_mem_read && (ex_rt != REG_AW'(REG_ZERO)) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign redirect_s  = ex_br_taken || ex_jump;
  assign mem_stall_s = mem_req && !mem_ready;

  // priority row select: first matching condition wins
  always_comb begin
    row_s = ROW_DEFAULT;
    if (reset) begin
      row_s = ROW_RESET;
    end else if (mem_stall_s) begin
      row_s = ROW_MEM_STALL;
    end else if (redirect_s) begin
      row_s = ROW_REDIRECT;
    end else if (state_r == ST_HALTED) begin
      row_s = ROW_HALTED;
    end else if (load_use_s) begin
      row_s = ROW_LOAD_USE;
    end else begin
      row_s = ROW_DEFAULT;
    end
  end

  assign ctrl_s      = row_ctrl(row_s);
  assign pc_write    = ctrl_s.pc_write;
  assign ifid_write  = ctrl_s.ifid_write;
  assign ifid_flush  = ctrl_s.ifid_flush;
  assign idex_write  = ctrl_s.idex_write;
  assign idex_flush  = ctrl_s.idex_flush;
  assign exmem_write = ctrl_s.exmem_write;
  assign memwb_flush = ctrl_s.memwb_flush;

  // debug FSM next state; a frozen pipeline holds the state
  always_comb begin
    state_nxt_s = state_r;
    if (mem_stall_s) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_RUN:    state_nxt_s = dbg_halt ? ST_HALTED : ST_RUN;
        ST_HALTED: begin
          if (!dbg_halt) begin
            state_nxt_s = ST_RUN;
          end else if (dbg_step) begin
            state_nxt_s = ST_STEP;
          end else begin
            state_nxt_s = ST_HALTED;
          end
        end
        ST_STEP: begin
          if (!dbg_halt) begin
            state_nxt_s = ST_RUN;
          end else if (row_s == ROW_DEFAULT) begin
            state_nxt_s = ST_HALTED;
          end else begin
            state_nxt_s = ST_STEP;
          end
        end
        default:   state_nxt_s = ST_RUN;
      endcase
    end
  end

  // debug FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign halted = (state_r == ST_HALTED);

  assign stall_en_s = (row_s == ROW_MEM_STALL) || (row_s == ROW_LOAD_USE);
  assign flush_en_s = (row_s == ROW_REDIRECT);
  assign wait_clr_s = reset || !mem_stall_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .en  (stall_en_s),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .en  (flush_en_s),
    .q   (flush_cnt)
  );

  sat_counter #(.W(8)) u_wait_cnt (
    .clk (clk),
    .clr (wait_clr_s),
    .en  (mem_stall_s),
    .q   (wait_cnt_s)
  );

  // sticky timeout: set on the stall cycle that brings wait_cnt to MEM_TIMEOUT
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_timeout_r <= 1'b0;
    end else if (mem_stall_s && (wait_cnt_s == WAIT_LAST)) begin
      mem_timeout_r <= 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// scoreboard queue, a negedge monitor pops and compares each cycle.
module tb_pipeline_hazard_ctrl;

  // control word order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f
  localparam logic [6:0] C_RST  = 7'b0010101;
  localparam logic [6:0] C_MST  = 7'b0000001;
  localparam logic [6:0] C_RED  = 7'b1111110;
  localparam logic [6:0] C_HLT  = 7'b0001110;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_DFL  = 7'b1101010;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic       halted;
    logic       tmo;
    int         stall;
    int         flush;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs = 5'd0;
  logic [4:0]  id_rt = 5'd0;
  logic        id_uses_rt = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        ex_br_taken = 1'b0;
  logic        ex_jump = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        dbg_halt = 1'b0;
  logic        dbg_step = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic        exmem_write, memwb_flush, halted, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .MEM_TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .ex_br_taken (ex_br_taken),
    .ex_jump     (ex_jump),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .dbg_halt    (dbg_halt),
    .dbg_step    (dbg_step),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_write  (idex_write),
    .idex_flush  (idex_flush),
    .exmem_write (exmem_write),
    .memwb_flush (memwb_flush),
    .halted      (halted),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
    end
  endtask

  // monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "ctrl", int'({pc_write, ifid_write, ifid_flush, idex_write,
                               idex_flush, exmem_write, memwb_flush}), int'(e.ctrl));
      chk(e.name, "halted", int'(halted), int'(e.halted));
      chk(e.name, "mem_timeout", int'(mem_timeout), int'(e.tmo));
      chk(e.name, "stall_cnt", int'(stall_cnt), e.stall);
      chk(e.name, "flush_cnt", int'(flush_cnt), e.flush);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_br_taken = 1'b0; ex_jump = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; dbg_halt = 1'b0; dbg_step = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [6:0] c, input logic h,
                            input logic t, input int s, input int f);
    exp_t e;
    e.name = nm; e.ctrl = c; e.halted = h; e.tmo = t; e.stall = s; e.flush = f;
    sb.push_back(e);
  endtask

  task automatic load_use_rs();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
  endtask

  initial begin
    next_cycle(); reset = 1'b1;
    expect_out("reset_row", C_RST, 1'b0, 1'b0, 0, 0);
    next_cycle();
    expect_out("idle", C_DFL, 1'b0, 1'b0, 0, 0);

    // load-use hazards
    next_cycle(); load_use_rs();
    expect_out("lu_rs", C_LU, 1'b0, 1'b0, 0, 0);
    next_cycle();
    expect_out("after_lu", C_DFL, 1'b0, 1'b0, 1, 0);
    next_cycle(); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd3;
    expect_out("lu_rt", C_LU, 1'b0, 1'b0, 1, 0);
    next_cycle(); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
    expect_out("rt_unused", C_DFL, 1'b0, 1'b0, 2, 0);
    next_cycle(); ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    expect_out("ld_r0", C_DFL, 1'b0, 1'b0, 2, 0);

    // redirects
    next_cycle(); load_use_rs(); ex_br_taken = 1'b1;
    expect_out("br_over_lu", C_RED, 1'b0, 1'b0, 2, 0);
    next_cycle(); ex_jump = 1'b1;
    expect_out("jump", C_RED, 1'b0, 1'b0, 2, 1);
    next_cycle();
    expect_out("after_redir", C_DFL, 1'b0, 1'b0, 2, 2);

    // 64-cycle memory wait; halt and branch requests are frozen out
    for (int i = 0; i < 64; i++) begin
      next_cycle(); mem_req = 1'b1; dbg_halt = (i < 2); ex_br_taken = (i == 0);
      expect_out("mem_wait", C_MST, 1'b0, 1'b0, 2 + i, 2);
    end
    next_cycle(); mem_req = 1'b1; mem_ready = 1'b1;
    expect_out("mem_done", C_DFL, 1'b0, 1'b1, 66, 2);
    next_cycle(); mem_req = 1'b1;
    expect_out("mem_wait1", C_MST, 1'b0, 1'b1, 66, 2);
    next_cycle();
    expect_out("tmo_sticky", C_DFL, 1'b0, 1'b1, 67, 2);

    // halt, idle, single step
    next_cycle(); dbg_halt = 1'b1;
    expect_out("halt_req", C_DFL, 1'b0, 1'b1, 67, 2);
    next_cycle(); dbg_halt = 1'b1;
    expect_out("halted1", C_HLT, 1'b1, 1'b1, 67, 2);
    next_cycle(); dbg_halt = 1'b1; load_use_rs();
    expect_out("halted_lu", C_HLT, 1'b1, 1'b1, 67, 2);
    next_cycle(); dbg_halt = 1'b1;
    expect_out("halted3", C_HLT, 1'b1, 1'b1, 67, 2);
    next_cycle(); dbg_halt = 1'b1; dbg_step = 1'b1;
    expect_out("step_req", C_HLT, 1'b1, 1'b1, 67, 2);
    next_cycle(); dbg_halt = 1'b1;
    expect_out("step_issue", C_DFL, 1'b0, 1'b1, 67, 2);
    next_cycle(); dbg_halt = 1'b1;
    expect_out("step_back", C_HLT, 1'b1, 1'b1, 67, 2);

    // step that waits on a load-use
    next_cycle(); dbg_halt = 1'b1; dbg_step = 1'b1;
    expect_out("step2_req", C_HLT, 1'b1, 1'b1, 67, 2);
    next_cycle(); dbg_halt = 1'b1; load_use_rs();
    expect_out("step_lu", C_LU, 1'b0, 1'b1, 67, 2);
    next_cycle(); dbg_halt = 1'b1;
    expect_out("step2_issue", C_DFL, 1'b0, 1'b1, 68, 2);
    next_cycle(); dbg_halt = 1'b1;
    expect_out("step2_back", C_HLT, 1'b1, 1'b1, 68, 2);

    // redirect while halted, then release
    next_cycle(); dbg_halt = 1'b1; ex_jump = 1'b1;
    expect_out("halt_jump", C_RED, 1'b1, 1'b1, 68, 2);
    next_cycle(); dbg_halt = 1'b1;
    expect_out("halt_stays", C_HLT, 1'b1, 1'b1, 68, 3);
    next_cycle();
    expect_out("release", C_HLT, 1'b1, 1'b1, 68, 3);
    next_cycle();
    expect_out("run_again", C_DFL, 1'b0, 1'b1, 68, 3);

    // STEP -> RUN when halt drops
    next_cycle(); dbg_halt = 1'b1;
    expect_out("halt_req2", C_DFL, 1'b0, 1'b1, 68, 3);
    next_cycle(); dbg_halt = 1'b1; dbg_step = 1'b1;
    expect_out("step3_req", C_HLT, 1'b1, 1'b1, 68, 3);
    next_cycle(); load_use_rs();
    expect_out("step_to_run", C_LU, 1'b0, 1'b1, 68, 3);
    next_cycle();
    expect_out("run_a", C_DFL, 1'b0, 1'b1, 69, 3);
    next_cycle();
    expect_out("run_b", C_DFL, 1'b0, 1'b1, 69, 3);
    next_cycle(); dbg_step = 1'b1;
    expect_out("step_in_run", C_DFL, 1'b0, 1'b1, 69, 3);
    next_cycle();
    expect_out("run_c", C_DFL, 1'b0, 1'b1, 69, 3);

    // reset during a memory wait
    for (int i = 0; i < 3; i++) begin
      next_cycle(); mem_req = 1'b1;
      expect_out("pre_reset_wait", C_MST, 1'b0, 1'b1, 69 + i, 3);
    end
    next_cycle(); reset = 1'b1; mem_req = 1'b1; dbg_halt = 1'b1;
    expect_out("reset_in_wait", C_RST, 1'b0, 1'b1, 72, 3);
    next_cycle();
    expect_out("post_reset", C_DFL, 1'b0, 1'b0, 0, 0);

    next_cycle();
    @(posedge clk);
    chk("scoreboard", "leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
